// File: rtl/subbytes_lane_sched_if.sv
// Bundle of the block handshakes and the shared S-box lane for subbytes_lane_sched.
//
// Purpose: groups the input block handshake, the output block handshake and
// the narrow S-box lane so the sequencer and its environment connect through
// one port.
//
// Signals:
//   in_valid / in_ready   input block handshake (accept when both high at an edge)
//   blocoIn               128-bit input state, byte 0 in bits [127:120]
//   sbox_in               LANES bytes sent to the external S-box lane
//   sbox_out              combinational S-box result for sbox_in
//   out_valid / out_ready output block handshake
//   blocoOut              128-bit substituted state, same byte order as blocoIn
//
// Modports:
//   master  environment side (round controller, S-box lane, ShiftRows stage)
//   slave   sequencer side
interface subbytes_lane_sched_if #(
  parameter int LANES = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [127:0]         blocoIn;
  logic [8*LANES-1:0]   sbox_in;
  logic [8*LANES-1:0]   sbox_out;
  logic                 out_valid;
  logic                 out_ready;
  logic [127:0]         blocoOut;

  modport master (
    output in_valid, blocoIn, sbox_out, out_ready,
    input  in_ready, sbox_in, out_valid, blocoOut
  );

  modport slave (
    input  in_valid, blocoIn, sbox_out, out_ready,
    output in_ready, sbox_in, out_valid, blocoOut
  );
endinterface

// File: rtl/subbytes_lane_sched.sv
// AES SubBytes sequencer over a narrow shared S-box lane.
//
// Purpose: accepts a 128-bit AES state, streams it LANES bytes per beat
// through an external combinational S-box lane, assembles the substituted
// state and offers it on a valid/ready output handshake. BEATS = 16/LANES.
//
// Ports:
//   clock    system clock, rising edge
//   reset    asynchronous, active-high reset
//   enableS  power enable; low stalls sequencing and zeroes the S-box operands
//   clear    synchronous abort of the block in flight (highest priority)
//   bus      subbytes_lane_sched_if.slave: block handshakes and S-box lane
//   busy     high while a block is being substituted or waiting for handoff
module subbytes_lane_sched #(
  parameter int LANES = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enableS,
  input  logic                        clear,
  subbytes_lane_sched_if.slave        bus,
  output logic                        busy
);

  localparam int BEATS = 16 / LANES;
  localparam int W     = 8 * LANES;
  localparam int SHL   = 128 - W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state, state_next;
  logic [BW-1:0]   beat, beat_next;
  logic [127:0]    cap;
  logic [127:0]    bloco_reg, bloco_next;
  logic            accept;
  logic            step;
  logic            last;
  logic [7:0]      shamt;
  logic [127:0]    lane_mask;
  logic [127:0]    lane_data;

  // A block is only taken while powered and not being aborted, so a clear
  // that coincides with in_valid never starts a block.
  assign accept = (state == IDLE) && bus.in_valid && enableS && !clear;
  assign step   = (state == RUN) && enableS;
  assign last   = (beat == BW'(BEATS - 1));

  // Byte group g starts at bit 127 - 8*LANES*g; shifting left by the group
  // offset brings the current group to the top of the word. Byte 0 is the
  // MSB byte, so lane 0 ends up in the MSB byte of sbox_in.
  assign shamt     = 8'(beat) * 8'(W);
  assign lane_mask = (~128'd0 << SHL) >> shamt;
  assign lane_data = (128'(bus.sbox_out) << SHL) >> shamt;

  // Next-state and result-assembly logic. clear overrides every transition
  // and also suppresses the write of the current beat so blocoOut keeps its
  // previous contents.
  always_comb begin
    state_next = state;
    beat_next  = beat;
    bloco_next = bloco_reg;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_next = RUN;
          beat_next  = '0;
        end
      end
      RUN: begin
        if (enableS) begin
          bloco_next = (bloco_reg & ~lane_mask) | lane_data;
          if (last) begin
            state_next = DONE;
            beat_next  = '0;
          end else begin
            beat_next = beat + 1'b1;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        beat_next  = '0;
      end
    endcase
    if (clear) begin
      state_next = IDLE;
      beat_next  = '0;
      bloco_next = bloco_reg;
    end
  end

  // State, beat counter, captured operand and assembled result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      beat      <= '0;
      cap       <= '0;
      bloco_reg <= '0;
    end else begin
      state     <= state_next;
      beat      <= beat_next;
      bloco_reg <= bloco_next;
      if (accept) begin
        cap <= bus.blocoIn;
      end
    end
  end

  // The S-box operand is forced to zero whenever no beat is being issued so
  // the shared lane sees no switching activity while idle or stalled.
  assign bus.sbox_in   = step ? W'((cap << shamt) >> SHL) : '0;
  assign bus.in_ready  = (state == IDLE) && enableS && !clear;
  assign bus.out_valid = (state == DONE);
  assign bus.blocoOut  = bloco_reg;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_subbytes_lane_sched.sv
// Self-checking bench for subbytes_lane_sched.
//
// Purpose: drives directed and randomized blocks through LANES=4, LANES=1 and
// LANES=16 instances, models the S-box lane from GF(2^8) arithmetic and
// compares handshakes, lane operands and results against a byte-wise
// reference.
module tb_subbytes_lane_sched;

  logic clock = 1'b0;
  logic reset;
  logic enable_s;
  logic clear;
  logic busy4, busy1, busy16;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox_tab [256];
  logic [127:0] last_out;

  always #5 clock = ~clock;

  subbytes_lane_sched_if #(.LANES(4))  bus4  ();
  subbytes_lane_sched_if #(.LANES(1))  bus1  ();
  subbytes_lane_sched_if #(.LANES(16)) bus16 ();

  subbytes_lane_sched #(.LANES(4)) dut4 (
    .clock(clock), .reset(reset), .enableS(enable_s), .clear(clear),
    .bus(bus4.slave), .busy(busy4)
  );
  subbytes_lane_sched #(.LANES(1)) dut1 (
    .clock(clock), .reset(reset), .enableS(enable_s), .clear(clear),
    .bus(bus1.slave), .busy(busy1)
  );
  subbytes_lane_sched #(.LANES(16)) dut16 (
    .clock(clock), .reset(reset), .enableS(enable_s), .clear(clear),
    .bus(bus16.slave), .busy(busy16)
  );

  // External combinational S-box lanes, one lookup per byte.
  for (genvar j = 0; j < 4; j++) begin : g_lane4
    assign bus4.sbox_out[8*j +: 8] = sbox_tab[bus4.sbox_in[8*j +: 8]];
  end
  assign bus1.sbox_out = sbox_tab[bus1.sbox_in];
  for (genvar j = 0; j < 16; j++) begin : g_lane16
    assign bus16.sbox_out[8*j +: 8] = sbox_tab[bus16.sbox_in[8*j +: 8]];
  end

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic hi;
    a = a_in; b = b_in; p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  // AES S-box: multiplicative inverse followed by the affine transform.
  function automatic logic [7:0] sboxCalc(input logic [7:0] x);
    logic [7:0] inv;
    inv = '0;
    for (int c = 1; c < 256; c++) begin
      if (gmul(x, 8'(c)) == 8'h01) inv = 8'(c);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] subBytesRef(input logic [127:0] blk);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) begin
      r[127-8*k -: 8] = sbox_tab[blk[127-8*k -: 8]];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One LANES=4 transaction: accept, BEATS beats with an optional stall of
  // stall_len cycles before beat stall_at, then hold out_ready low for hold
  // cycles while a competing in_valid is offered.
  task automatic applyStimulus(input string name, input logic [127:0] blk,
                               input int stall_at, input int stall_len, input int hold);
    logic [127:0] ref_out, grp;
    int beats_done, stalled, guard;
    ref_out = subBytesRef(blk);
    enable_s = 1'b1;
    bus4.blocoIn = blk;
    bus4.in_valid = 1'b1;
    bus4.out_ready = 1'b0;
    #1;
    checkOutput({name, "/in_ready_idle"}, 128'(bus4.in_ready), 128'd1);
    tick();
    bus4.in_valid = 1'b0;
    bus4.blocoIn = ~blk;
    beats_done = 0; stalled = 0; guard = 0;
    while (beats_done < 4 && guard < 64) begin
      enable_s = !(beats_done == stall_at && stalled < stall_len);
      #1;
      grp = enable_s ? ((blk >> (96 - 32*beats_done)) & 128'hffff_ffff) : 128'd0;
      checkOutput({name, "/sbox_in"}, 128'(bus4.sbox_in), grp);
      checkOutput({name, "/out_valid_early"}, 128'(bus4.out_valid), 128'd0);
      checkOutput({name, "/busy_run"}, 128'(busy4), 128'd1);
      tick();
      guard++;
      if (enable_s) beats_done++; else stalled++;
    end
    enable_s = 1'b1;
    #1;
    checkOutput({name, "/out_valid"}, 128'(bus4.out_valid), 128'd1);
    checkOutput({name, "/result"}, bus4.blocoOut, ref_out);
    checkOutput({name, "/in_ready_done"}, 128'(bus4.in_ready), 128'd0);
    bus4.blocoIn = {$urandom, $urandom, $urandom, $urandom};
    bus4.in_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      enable_s = 1'($urandom_range(0, 1));
      #1;
      checkOutput({name, "/hold_valid"}, 128'(bus4.out_valid), 128'd1);
      checkOutput({name, "/hold_result"}, bus4.blocoOut, ref_out);
      checkOutput({name, "/hold_in_ready"}, 128'(bus4.in_ready), 128'd0);
      tick();
    end
    enable_s = 1'b1;
    bus4.out_ready = 1'b1;
    tick();
    bus4.out_ready = 1'b0;
    checkOutput({name, "/handoff_valid"}, 128'(bus4.out_valid), 128'd0);
    checkOutput({name, "/handoff_not_accepted"}, 128'(busy4), 128'd0);
    checkOutput({name, "/in_ready_after"}, 128'(bus4.in_ready), 128'd1);
    bus4.in_valid = 1'b0;
    last_out = ref_out;
  endtask

  // One transaction on the LANES=1 or LANES=16 instance, measuring latency.
  task automatic runOther(input int lanes, input logic [127:0] blk);
    logic [127:0] ref_out, obs;
    logic ov;
    int cyc;
    ref_out = subBytesRef(blk);
    enable_s = 1'b1;
    if (lanes == 1) begin
      bus1.blocoIn = blk; bus1.in_valid = 1'b1;
    end else begin
      bus16.blocoIn = blk; bus16.in_valid = 1'b1;
    end
    tick();
    bus1.in_valid = 1'b0;
    bus16.in_valid = 1'b0;
    cyc = 0;
    ov = (lanes == 1) ? bus1.out_valid : bus16.out_valid;
    while (!ov && cyc < 40) begin
      tick();
      cyc++;
      ov = (lanes == 1) ? bus1.out_valid : bus16.out_valid;
    end
    checkOutput($sformatf("lanes%0d/latency", lanes), 128'(cyc), 128'(16 / lanes));
    obs = (lanes == 1) ? bus1.blocoOut : bus16.blocoOut;
    checkOutput($sformatf("lanes%0d/result", lanes), obs, ref_out);
    bus1.out_ready = 1'b1;
    bus16.out_ready = 1'b1;
    tick();
    bus1.out_ready = 1'b0;
    bus16.out_ready = 1'b0;
    ov = (lanes == 1) ? bus1.out_valid : bus16.out_valid;
    checkOutput($sformatf("lanes%0d/handoff", lanes), 128'(ov), 128'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [127:0] blk, partial;

    reset = 1'b1;
    enable_s = 1'b1;
    clear = 1'b0;
    bus4.in_valid = 1'b0;  bus4.out_ready = 1'b0;  bus4.blocoIn = '0;
    bus1.in_valid = 1'b0;  bus1.out_ready = 1'b0;  bus1.blocoIn = '0;
    bus16.in_valid = 1'b0; bus16.out_ready = 1'b0; bus16.blocoIn = '0;
    for (int i = 0; i < 256; i++) sbox_tab[i] = sboxCalc(8'(i));
    last_out = '0;
    #12;

    $display("[TB] reset state");
    checkOutput("rst/out_valid", 128'(bus4.out_valid), 128'd0);
    checkOutput("rst/blocoOut", bus4.blocoOut, 128'd0);
    checkOutput("rst/in_ready", 128'(bus4.in_ready), 128'd1);
    checkOutput("rst/busy", 128'(busy4), 128'd0);
    checkOutput("rst/sbox_in", 128'(bus4.sbox_in), 128'd0);
    reset = 1'b0;
    tick();

    $display("[TB] known vector, no stall");
    applyStimulus("vec", 128'h00112233445566778899aabbccddeeff, -1, 0, 0);
    checkOutput("vec/const", bus4.blocoOut, 128'h638293c31bfc33f5c4eeacea4bc12816);

    $display("[TB] known vector, stall at beat 2");
    applyStimulus("stall", 128'h00112233445566778899aabbccddeeff, 2, 3, 0);
    checkOutput("stall/const", bus4.blocoOut, 128'h638293c31bfc33f5c4eeacea4bc12816);

    $display("[TB] output back-pressure");
    applyStimulus("hold", {$urandom, $urandom, $urandom, $urandom}, -1, 0, 5);

    $display("[TB] clear at beat 1");
    blk = {$urandom, $urandom, $urandom, $urandom};
    bus4.blocoIn = blk;
    bus4.in_valid = 1'b1;
    tick();
    bus4.in_valid = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    #1;
    partial = subBytesRef(blk);
    partial[95:0] = last_out[95:0];
    checkOutput("clear/busy", 128'(busy4), 128'd0);
    checkOutput("clear/out_valid", 128'(bus4.out_valid), 128'd0);
    checkOutput("clear/blocoOut_kept", bus4.blocoOut, partial);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("clear/no_out_valid", 128'(bus4.out_valid), 128'd0);
    end

    $display("[TB] clear with in_valid in idle");
    bus4.blocoIn = blk;
    bus4.in_valid = 1'b1;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    bus4.in_valid = 1'b0;
    #1;
    checkOutput("clear_idle/not_accepted", 128'(busy4), 128'd0);

    $display("[TB] all-zero block");
    applyStimulus("zero", 128'd0, -1, 0, 0);
    checkOutput("zero/const", bus4.blocoOut, {16{8'h63}});

    $display("[TB] asynchronous reset mid-run");
    bus4.blocoIn = {$urandom, $urandom, $urandom, $urandom};
    bus4.in_valid = 1'b1;
    tick();
    bus4.in_valid = 1'b0;
    tick();
    #2;
    reset = 1'b1;
    #1;
    checkOutput("arst/out_valid", 128'(bus4.out_valid), 128'd0);
    checkOutput("arst/blocoOut", bus4.blocoOut, 128'd0);
    checkOutput("arst/in_ready", 128'(bus4.in_ready), 128'd1);
    checkOutput("arst/busy", 128'(busy4), 128'd0);
    checkOutput("arst/sbox_in", 128'(bus4.sbox_in), 128'd0);
    #1;
    reset = 1'b0;
    last_out = '0;
    tick();

    $display("[TB] randomized blocks");
    for (int n = 0; n < 4; n++) begin
      applyStimulus($sformatf("rnd%0d", n), {$urandom, $urandom, $urandom, $urandom},
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 3)));
    end

    $display("[TB] LANES=1 and LANES=16");
    runOther(1, {16{8'hff}});
    checkOutput("lanes1/const", bus1.blocoOut, {16{8'h16}});
    runOther(16, {16{8'hff}});
    checkOutput("lanes16/const", bus16.blocoOut, {16{8'h16}});
    runOther(1, {$urandom, $urandom, $urandom, $urandom});
    runOther(16, {$urandom, $urandom, $urandom, $urandom});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
